// File: rtl/number_pkg.sv
// Shared definitions for the keypad number-entry block: default value width
// and ceiling, FSM state encoding, the BCD digit type and the largest legal
// decimal digit.
package number_pkg;

    localparam int WIDTH_DEF     = 13;
    localparam int MAX_VALUE_DEF = 8191;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ENTRY = 2'd1,
        HOLD  = 2'd2
    } state_e;

    typedef logic [3:0] bcd_t;

    localparam bcd_t DIGIT_MAX = 4'd9;

endpackage

// File: rtl/mul10_add.sv
// mul10_add: combinational value*10 + digit with range check.
//
// Ports:
//   value_i     in  WIDTH  current accumulated value
//   digit_i     in  4      BCD digit to append
//   candidate_o out WIDTH  value*10 + digit (low WIDTH bits)
//   ok_o        out 1      candidate fits within MAX_VALUE
module mul10_add
    import number_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter int MAX_VALUE = MAX_VALUE_DEF
) (
    input  logic [WIDTH-1:0] value_i,
    input  bcd_t             digit_i,
    output logic [WIDTH-1:0] candidate_o,
    output logic             ok_o
);

    // Four extra bits hold any value*10+9 without wrapping, so the range
    // compare sees the true result.
    logic [WIDTH+3:0] value_ext;
    logic [WIDTH+3:0] wide;

    assign value_ext   = {4'b0000, value_i};
    assign wide        = (value_ext << 3) + (value_ext << 1) + (WIDTH+4)'(digit_i);
    assign ok_o        = (wide <= (WIDTH+4)'(MAX_VALUE));
    assign candidate_o = wide[WIDTH-1:0];

endmodule

// File: rtl/number_entry.sv
// number_entry: accumulates decimal key digits into a binary value with
// clear / backspace / enter editing, then offers the committed value on a
// valid/ready handshake.
//
// Ports:
//   clk          in  1      system clock, rising edge
//   rst          in  1      synchronous active-high reset
//   digit_valid  in  1      strobe: digit is valid
//   digit        in  4      BCD digit (0..9 legal)
//   backspace    in  1      strobe: drop last digit
//   clear        in  1      strobe: discard entry
//   enter        in  1      strobe: commit entry
//   value        out WIDTH  live accumulated value
//   digit_count  out 3      significant digits held
//   can_num      out 4      digit-position enables, bit i = count > i
//   out_valid    out 1      committed value available
//   out_ready    in  1      consumer accepts committed value
//   out_value    out WIDTH  committed value
//   err          out 1      one-cycle pulse on rejected input
//
// Build option: define NUMBER_ENTRY_TIMEOUT_EN to clear an idle entry after
// TIMEOUT_CYCLES cycles without any strobe.
module number_entry
    import number_pkg::*;
#(
    parameter int WIDTH          = WIDTH_DEF,
    parameter int MAX_DIGITS     = 4,
    parameter int MAX_VALUE      = MAX_VALUE_DEF,
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             digit_valid,
    input  bcd_t             digit,
    input  logic             backspace,
    input  logic             clear,
    input  logic             enter,
    output logic [WIDTH-1:0] value,
    output logic [2:0]       digit_count,
    output logic [3:0]       can_num,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_value,
    output logic             err
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] value_q, value_d;
    logic [2:0]       count_q, count_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_value_q, out_value_d;
    logic             err_q, err_d;

    logic [WIDTH-1:0] candidate;
    logic             candidate_ok;
    logic             digit_legal;

    // Only the highest-priority command in a cycle acts.
    logic cmd_clear, cmd_enter, cmd_bksp, cmd_digit;
    logic timeout_hit;

    assign cmd_clear   = clear;
    assign cmd_enter   = enter && !clear;
    assign cmd_bksp    = backspace && !clear && !enter;
    assign cmd_digit   = digit_valid && !clear && !enter && !backspace;
    assign digit_legal = (digit <= DIGIT_MAX);

    mul10_add #(
        .WIDTH     (WIDTH),
        .MAX_VALUE (MAX_VALUE)
    ) u_mul10_add (
        .value_i     (value_q),
        .digit_i     (digit),
        .candidate_o (candidate),
        .ok_o        (candidate_ok)
    );

`ifdef NUMBER_ENTRY_TIMEOUT_EN
    localparam int TW = ($clog2(TIMEOUT_CYCLES) < 1) ? 1 : $clog2(TIMEOUT_CYCLES);

    logic [TW-1:0] idle_q, idle_d;
    logic          any_strobe;

    assign any_strobe  = digit_valid || backspace || clear || enter;
    assign timeout_hit = (state_q == ENTRY) && !any_strobe &&
                         (idle_q == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        idle_d = '0;
        if (state_q == ENTRY && !any_strobe && !timeout_hit) begin
            idle_d = idle_q + TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) idle_q <= '0;
        else     idle_q <= idle_d;
    end
`else
    logic unused_timeout;

    assign timeout_hit    = 1'b0;
    assign unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

    always_comb begin
        // NOTE: every next-state signal takes its hold value first so no path
        // through the case leaves one unassigned (which would infer a latch).
        state_d     = state_q;
        value_d     = value_q;
        count_d     = count_q;
        out_valid_d = out_valid_q;
        out_value_d = out_value_q;
        err_d       = 1'b0;

        unique case (state_q)
            EMPTY: begin
                if (cmd_digit) begin
                    if (digit_legal) begin
                        value_d = WIDTH'(digit);
                        count_d = 3'd1;
                        state_d = ENTRY;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            ENTRY: begin
                if (cmd_clear || timeout_hit) begin
                    value_d = '0;
                    count_d = 3'd0;
                    state_d = EMPTY;
                end else if (cmd_enter) begin
                    out_value_d = value_q;
                    out_valid_d = 1'b1;
                    value_d     = '0;
                    count_d     = 3'd0;
                    state_d     = HOLD;
                end else if (cmd_bksp) begin
                    value_d = value_q / WIDTH'(10);
                    count_d = count_q - 3'd1;
                    if (count_q == 3'd1) begin
                        value_d = '0;
                        state_d = EMPTY;
                    end
                end else if (cmd_digit) begin
                    if (!digit_legal) begin
                        err_d = 1'b1;
                    end else if (value_q == '0 && count_q == 3'd1) begin
                        // A lone zero is replaced rather than extended.
                        value_d = WIDTH'(digit);
                    end else if (count_q == 3'(MAX_DIGITS) || !candidate_ok) begin
                        err_d = 1'b1;
                    end else begin
                        value_d = candidate;
                        count_d = count_q + 3'd1;
                    end
                end
            end

            HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = EMPTY;
                end
                // Clear is ignored so a pending handshake is never aborted.
                if (cmd_enter || cmd_bksp || cmd_digit) begin
                    err_d = 1'b1;
                end
            end

            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others, matching the hardware.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            value_q     <= '0;
            count_q     <= 3'd0;
            out_valid_q <= 1'b0;
            out_value_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            value_q     <= value_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_value_q <= out_value_d;
            err_q       <= err_d;
        end
    end

    assign value       = value_q;
    assign digit_count = count_q;
    assign can_num     = {count_q > 3'd3, count_q > 3'd2, count_q > 3'd1, 1'b1};
    assign out_valid   = out_valid_q;
    assign out_value   = out_value_q;
    assign err         = err_q;

endmodule

// File: tb/tb_number_entry.sv
// Self-checking bench for number_entry. Committed values are pushed to a
// scoreboard queue when enter is driven and popped when the handshake fires.
module tb_number_entry;
    import number_pkg::*;

    localparam int WIDTH = 13;

    logic             clk = 1'b0;
    logic             rst;
    logic             digit_valid;
    bcd_t             digit;
    logic             backspace;
    logic             clear;
    logic             enter;
    logic [WIDTH-1:0] value;
    logic [2:0]       digit_count;
    logic [3:0]       can_num;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_value;
    logic             err;

    int checks = 0;
    int errors = 0;
    int unsigned sb_q[$];

    number_entry #(
        .WIDTH          (WIDTH),
        .MAX_DIGITS     (4),
        .MAX_VALUE      (8191),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .digit_valid (digit_valid),
        .digit       (digit),
        .backspace   (backspace),
        .clear       (clear),
        .enter       (enter),
        .value       (value),
        .digit_count (digit_count),
        .can_num     (can_num),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_value   (out_value),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Inputs settle 1 time unit after the rising edge; outputs are read there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        digit_valid = 1'b0;
        digit       = 4'd0;
        backspace   = 1'b0;
        clear       = 1'b0;
        enter       = 1'b0;
    endtask

    task automatic press_digit(input int d);
        digit_valid = 1'b1;
        digit       = 4'(d);
        tick();
        idle_inputs();
    endtask

    task automatic press_enter(input int expect_commit);
        if (expect_commit >= 0) sb_q.push_back(expect_commit);
        enter = 1'b1;
        tick();
        idle_inputs();
    endtask

    // Scoreboard pop: a handshake completes at the edge following a cycle
    // where out_valid and out_ready are both high.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb_q.size() == 0) check("sb_unexpected", 32'(out_value), 32'hFFFF_FFFF);
            else                  check("sb_value", 32'(out_value), sb_q.pop_front());
        end
    end

    initial begin
        int hi_cycles;

        idle_inputs();
        out_ready = 1'b0;
        rst       = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_value", 32'(value), 0);
        check("rst_count", 32'(digit_count), 0);
        check("rst_can_num", 32'(can_num), 4'b0001);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_value", 32'(out_value), 0);
        check("rst_err", 32'(err), 0);

        // 1,2,3,4 then enter with delayed ready
        press_digit(1);
        check("d1_value", 32'(value), 1);
        check("d1_can_num", 32'(can_num), 4'b0001);
        press_digit(2);
        check("d12_can_num", 32'(can_num), 4'b0011);
        press_digit(3);
        press_digit(4);
        check("d1234_value", 32'(value), 1234);
        check("d1234_count", 32'(digit_count), 4);
        check("d1234_can_num", 32'(can_num), 4'b1111);
        press_enter(1234);
        check("commit_out_value", 32'(out_value), 1234);
        check("commit_value_cleared", 32'(value), 0);
        check("commit_count_cleared", 32'(digit_count), 0);
        hi_cycles = 0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) out_ready = 1'b1;
            if (out_valid) hi_cycles++;
            check("hold_out_value", 32'(out_value), 1234);
            tick();
        end
        out_ready = 1'b0;
        check("hold_cycles", 32'(hi_cycles), 4);
        check("released_out_valid", 32'(out_valid), 0);

        // 8,1,9 then 2 overflows; 1 fits exactly
        press_digit(8);
        press_digit(1);
        press_digit(9);
        press_digit(2);
        check("ovf_err", 32'(err), 1);
        check("ovf_value", 32'(value), 819);
        check("ovf_count", 32'(digit_count), 3);
        tick();
        check("ovf_err_pulse", 32'(err), 0);
        press_digit(1);
        check("max_value", 32'(value), 8191);
        check("max_err", 32'(err), 0);
        press_digit(5);
        check("max_digits_err", 32'(err), 1);
        check("max_digits_value", 32'(value), 8191);
        clear = 1'b1;
        tick();
        idle_inputs();
        check("clear_value", 32'(value), 0);
        check("clear_count", 32'(digit_count), 0);

        // Leading zeros, backspace to empty, enter in EMPTY
        press_digit(0);
        check("lz0_count", 32'(digit_count), 1);
        press_digit(0);
        check("lz00_value", 32'(value), 0);
        check("lz00_count", 32'(digit_count), 1);
        press_digit(7);
        check("lz7_value", 32'(value), 7);
        check("lz7_count", 32'(digit_count), 1);
        backspace = 1'b1;
        tick();
        idle_inputs();
        check("bksp_empty_value", 32'(value), 0);
        check("bksp_empty_count", 32'(digit_count), 0);
        press_enter(-1);
        check("empty_enter_valid", 32'(out_valid), 0);
        check("empty_enter_err", 32'(err), 0);

        // clear beats enter and digit in the same cycle
        press_digit(5);
        clear       = 1'b1;
        enter       = 1'b1;
        digit_valid = 1'b1;
        digit       = 4'd3;
        tick();
        idle_inputs();
        check("prio_value", 32'(value), 0);
        check("prio_count", 32'(digit_count), 0);
        check("prio_err", 32'(err), 0);
        check("prio_valid", 32'(out_valid), 0);

        // Illegal digit, enter beats backspace, HOLD rejections
        press_digit(12);
        check("illegal_err", 32'(err), 1);
        check("illegal_count", 32'(digit_count), 0);
        press_digit(4);
        press_digit(2);
        sb_q.push_back(42);
        enter     = 1'b1;
        backspace = 1'b1;
        tick();
        idle_inputs();
        check("enter_bksp_valid", 32'(out_valid), 1);
        check("enter_bksp_value", 32'(out_value), 42);
        check("enter_bksp_err", 32'(err), 0);
        press_digit(6);
        check("hold_digit_err", 32'(err), 1);
        check("hold_digit_out_value", 32'(out_value), 42);
        clear = 1'b1;
        tick();
        idle_inputs();
        check("hold_clear_err", 32'(err), 0);
        check("hold_clear_valid", 32'(out_valid), 1);
        out_ready = 1'b1;
        press_digit(7);
        out_ready = 1'b0;
        check("hold_ready_digit_err", 32'(err), 1);
        check("hold_ready_digit_valid", 32'(out_valid), 0);
        check("hold_ready_digit_value", 32'(value), 0);

        // Backspace from two digits, reset mid-entry
        press_digit(5);
        press_digit(6);
        backspace = 1'b1;
        tick();
        idle_inputs();
        check("bksp_value", 32'(value), 5);
        check("bksp_count", 32'(digit_count), 1);
        press_digit(6);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_entry_value", 32'(value), 0);
        check("rst_entry_count", 32'(digit_count), 0);

        // Reset during HOLD drops the pending value
        press_digit(3);
        press_enter(-1);
        check("pre_rst_hold_valid", 32'(out_valid), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_hold_valid", 32'(out_valid), 0);
        check("rst_hold_can_num", 32'(can_num), 4'b0001);
        check("rst_hold_value", 32'(value), 0);

`ifdef NUMBER_ENTRY_TIMEOUT_EN
        press_digit(9);
        for (int i = 0; i < 15; i++) tick();
        check("tmo_before_value", 32'(value), 9);
        tick();
        check("tmo_after_value", 32'(value), 0);
        check("tmo_after_count", 32'(digit_count), 0);
        check("tmo_err", 32'(err), 0);
`else
        press_digit(9);
        for (int i = 0; i < 40; i++) tick();
        check("no_tmo_value", 32'(value), 9);
`endif

        check("sb_drain", 32'(sb_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/number_entry.md
Name: number_entry

Overview:
- Converts a stream of decimal key digits into a binary value. This is the BCD to binary direction of our binary to BCD display splitter.
- Accumulates up to 4 digits with clear, backspace and enter, then presents the committed 13-bit value through a valid/ready handshake.
- Sits between keypad decode and game logic. The live `value`/`can_num` feed the existing display path while the user types.

Parameters:
- WIDTH, 13, bit width of the accumulated value.
- MAX_DIGITS, 4, maximum number of significant digits accepted.
- MAX_VALUE, 8191, largest value accepted; must be ≤ 2^WIDTH−1.
- TIMEOUT_CYCLES, 50_000_000, idle cycles before auto-clear (used only with the optional feature).

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- digit_valid  in  1  single-cycle strobe: `digit` is valid.
- digit  in  4  BCD digit, legal range 0–9.
- backspace  in  1  strobe: remove the last digit.
- clear  in  1  strobe: discard the entry.
- enter  in  1  strobe: commit the entry.
- value  out  WIDTH  current accumulated binary value.
- digit_count  out  3  number of significant digits held, 0..MAX_DIGITS.
- can_num  out  4  digit-position enables; bit i = (digit_count > i); bit 0 is always 1.
- out_valid  out  1  committed value is available.
- out_ready  in  1  consumer accepts the committed value.
- out_value  out  WIDTH  committed value; stable while `out_valid` is high.
- err  out  1  one-cycle pulse when an input is rejected.

Behaviour:
- Reset (sync, rst=1): state=EMPTY; value=0, digit_count=0, can_num=4'b0001, out_valid=0, out_value=0, err=0.
- FSM states are EMPTY, ENTRY and HOLD. All outputs are registered; every effect appears the cycle after the strobe.
- Command priority within a cycle: clear > enter > backspace > digit_valid. Only the highest-priority asserted command acts. Lower-priority commands are dropped silently, with no err.
- EMPTY:
  - A digit d≤9 sets value=d, digit_count=1 and moves to ENTRY.
  - enter, backspace and clear are ignored with no err.
- ENTRY, digit d:
  - If value==0 and digit_count==1, leading-zero replacement applies: value=d and count stays 1.
  - Otherwise the candidate is value*10+d, computed as (v<<3)+(v<<1)+d at WIDTH+4 bits.
  - Reject with an err pulse, state unchanged, if digit_count==MAX_DIGITS or candidate>MAX_VALUE.
  - On accept, value=candidate and digit_count+1.
- ENTRY, backspace:
  - value=value/10 and digit_count−1.
  - If the count reaches 0, go to EMPTY with value=0.
- ENTRY, clear: go to EMPTY with value=0 and count=0.
- ENTRY, enter:
  - out_value=value and out_valid=1; go to HOLD.
  - value and digit_count reset to 0.
- HOLD:
  - out_valid stays high and out_value stays constant until a cycle with out_ready=1. The next cycle has out_valid=0 and state=EMPTY.
  - digit_valid, backspace and enter in HOLD are rejected with an err pulse.
  - clear in HOLD is ignored; a handshake is never aborted.
- Illegal digit (>9) in any state: err pulse, no other change.
- Simultaneous out_ready and digit in the HOLD cycle: the handshake completes and the digit is rejected with err.
- rst asserted mid-entry or mid-HOLD returns everything to reset values on the next edge. A pending out_valid is dropped.

Optional Feature:
- Macro NUMBER_ENTRY_TIMEOUT_EN.
- Defined:
  - A counter of width $clog2(TIMEOUT_CYCLES) increments each cycle in ENTRY with no strobe, and resets on any strobe.
  - At TIMEOUT_CYCLES−1 it performs an implicit clear: ENTRY→EMPTY, no err. HOLD is unaffected.
- Undefined: no counter exists; an entry persists indefinitely.

Decomposition:
- Package number_pkg holds:
  - the WIDTH and MAX_VALUE defaults;
  - the state typedef (EMPTY/ENTRY/HOLD);
  - a BCD digit typedef (4-bit);
  - the constant DIGIT_MAX=9.
- One natural sub-module, mul10_add: combinational value*10+d with overflow compare against MAX_VALUE. It returns the candidate and an `ok` flag.

Test Plan:
- Digits 1,2,3,4 then enter, with out_ready held 0 for 3 cycles then 1:
  - out_value=1234 and out_valid held high for 4 cycles, then 0.
  - digit_count reads 4 before enter.
- Digits 8,1,9 then 2: the fourth digit gives candidate 8192>8191, so err pulses and value stays 819. Digit 1 gives 8191, accepted.
- Digits 0,0,7: value=7 and digit_count=1. Backspace goes to EMPTY with value=0. Enter in EMPTY produces no out_valid and no err.
- Digit 5 with clear and enter asserted in the same cycle as a following digit 3: clear wins, giving value=0, EMPTY, no err, no commit.
- Digit 12 gives an err pulse with no change. Digit 6 during HOLD gives err and out_value unchanged.
- rst=1 for one cycle during HOLD gives out_valid=0, can_num=4'b0001 and value=0 on the next edge. With NUMBER_ENTRY_TIMEOUT_EN and TIMEOUT_CYCLES=16, an idle ENTRY clears after 16 cycles.
